// File: rtl/huffman_symbol_sequencer_if.sv
// Block-in / symbol-out bundle for huffman_symbol_sequencer.
//   zigzag_pix_in : 64 signed 8-bit coefficients, coefficient k at [8k+7:8k]
//   blk_valid/blk_ready : block handshake
//   dc_pred_clr   : clear DC predictor (frame/scan start)
//   sym_valid/sym_ready : symbol handshake
//   sym_is_dc, sym_run, sym_size, sym_amp, sym_last : symbol fields
//   busy          : block in progress
interface huffman_symbol_sequencer_if;
  logic [511:0] zigzag_pix_in;
  logic         blk_valid;
  logic         blk_ready;
  logic         dc_pred_clr;
  logic         sym_valid;
  logic         sym_ready;
  logic         sym_is_dc;
  logic [3:0]   sym_run;
  logic [3:0]   sym_size;
  logic [7:0]   sym_amp;
  logic         sym_last;
  logic         busy;

  modport slave (
    input  zigzag_pix_in, blk_valid, dc_pred_clr, sym_ready,
    output blk_ready, sym_valid, sym_is_dc, sym_run, sym_size, sym_amp,
           sym_last, busy
  );

  modport master (
    output zigzag_pix_in, blk_valid, dc_pred_clr, sym_ready,
    input  blk_ready, sym_valid, sym_is_dc, sym_run, sym_size, sym_amp,
           sym_last, busy
  );
endinterface

// File: rtl/huffman_symbol_sequencer.sv
// Run-length sequencer ahead of the Huffman code stage. Accepts one 8x8
// zigzag-ordered block, emits the DC difference symbol against a running
// predictor, then (run, size, amp) symbols for AC 1..63 with ZRL and EOB.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : block input, predictor clear, symbol output handshake, busy
module huffman_symbol_sequencer (
  input  logic                              clock,
  input  logic                              reset_n,
  huffman_symbol_sequencer_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, DC, SCAN, DONE} state_t;

  state_t              state, state_n;
  logic [511:0]        blk, blk_n;
  logic [7:0]          pred, pred_n;
  logic [5:0]          k, k_n;
  logic [5:0]          run, run_n;

  logic                out_valid, valid_n;
  logic                out_is_dc, is_dc_n;
  logic [3:0]          out_run, out_run_n;
  logic [3:0]          out_size, size_n;
  logic [7:0]          out_amp, amp_n;
  logic                out_last, last_n;

  logic                out_free;
  logic [5:0]          cur_k;
  logic [5:0]          cur_run;
  logic [7:0]          coef;
  logic [3:0]          ac_size;
  logic [7:0]          ac_amp;
  logic [7:0]          dc_base;
  logic [8:0]          diff;
  logic [3:0]          dc_size;
  logic [7:0]          dc_amp;

  // Magnitude category: bit length of |v|.
  function automatic logic [3:0] size_of(input logic signed [8:0] v);
    logic [8:0] mag;
    mag = v[8] ? -v : v;
    size_of = '0;
    for (int unsigned i = 0; i < 9; i++)
      if (mag[i]) size_of = 4'(i + 1);
  endfunction

  // Amplitude bits: v for v>0, low size bits of v-1 for v<0.
  function automatic logic [7:0] amp_of(input logic signed [8:0] v,
                                        input logic [3:0] size);
    logic [7:0] t;
    logic [7:0] mask;
    t    = v[8] ? 8'(v - 9'sd1) : v[7:0];
    mask = 8'((9'd1 << size) - 9'd1);
    return t & mask;
  endfunction

  assign out_free = !out_valid || bus.sym_ready;

  // The DC handshake cycle also evaluates coefficient 1, so a block with
  // all AC nonzero streams one symbol per cycle with no bubble after DC.
  assign cur_k   = (state == DC) ? 6'd1 : k;
  assign cur_run = (state == DC) ? '0   : run;
  assign coef    = blk[{cur_k, 3'b000} +: 8];
  assign ac_size = size_of({coef[7], coef});
  assign ac_amp  = amp_of({coef[7], coef}, ac_size);

  assign dc_base = bus.dc_pred_clr ? '0 : pred;
  assign diff    = {bus.zigzag_pix_in[7], bus.zigzag_pix_in[7:0]}
                 - {dc_base[7], dc_base};
  assign dc_size = size_of(diff);
  assign dc_amp  = amp_of(diff, dc_size);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    blk_n     = blk;
    pred_n    = bus.dc_pred_clr ? '0 : pred;
    k_n       = k;
    run_n     = run;
    valid_n   = out_valid && !bus.sym_ready;
    is_dc_n   = out_is_dc;
    out_run_n = out_run;
    size_n    = out_size;
    amp_n     = out_amp;
    last_n    = out_last;

    unique case (state)
      IDLE: begin
        if (bus.blk_valid) begin
          blk_n     = bus.zigzag_pix_in;
          pred_n    = bus.zigzag_pix_in[7:0];
          k_n       = '0;
          run_n     = '0;
          valid_n   = 1'b1;
          is_dc_n   = 1'b1;
          out_run_n = '0;
          size_n    = dc_size;
          amp_n     = dc_amp;
          last_n    = 1'b0;
          state_n   = DC;
        end
      end
      DC: begin
        if (out_free) begin
          state_n = SCAN;
          k_n     = 6'd1;
          run_n   = '0;
        end
      end
      SCAN: begin
      end
      DONE: begin
        if (out_free) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if ((state == DC || state == SCAN) && out_free) begin
      if (coef == '0) begin
        run_n = cur_run + 6'd1;
        if (cur_k == 6'd63) begin
          // Trailing zeros collapse into EOB; never ZRL.
          valid_n   = 1'b1;
          is_dc_n   = 1'b0;
          out_run_n = '0;
          size_n    = '0;
          amp_n     = '0;
          last_n    = 1'b1;
          state_n   = DONE;
        end else begin
          k_n = cur_k + 6'd1;
        end
      end else if (cur_run >= 6'd16) begin
        // ZRL consumes 16 zeros; k stays put so the coefficient is retried.
        valid_n   = 1'b1;
        is_dc_n   = 1'b0;
        out_run_n = 4'd15;
        size_n    = '0;
        amp_n     = '0;
        last_n    = 1'b0;
        run_n     = cur_run - 6'd16;
        k_n       = cur_k;
      end else begin
        valid_n   = 1'b1;
        is_dc_n   = 1'b0;
        out_run_n = cur_run[3:0];
        size_n    = ac_size;
        amp_n     = ac_amp;
        last_n    = (cur_k == 6'd63);
        run_n     = '0;
        if (cur_k == 6'd63) state_n = DONE;
        else                k_n     = cur_k + 6'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk       <= '0;
      pred      <= '0;
      k         <= '0;
      run       <= '0;
      out_valid <= 1'b0;
      out_is_dc <= 1'b0;
      out_run   <= '0;
      out_size  <= '0;
      out_amp   <= '0;
      out_last  <= 1'b0;
    end else begin
      blk       <= blk_n;
      pred      <= pred_n;
      k         <= k_n;
      run       <= run_n;
      out_valid <= valid_n;
      out_is_dc <= is_dc_n;
      out_run   <= out_run_n;
      out_size  <= size_n;
      out_amp   <= amp_n;
      out_last  <= last_n;
    end
  end

  assign bus.blk_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.sym_valid = out_valid;
  assign bus.sym_is_dc = out_is_dc;
  assign bus.sym_run   = out_run;
  assign bus.sym_size  = out_size;
  assign bus.sym_amp   = out_amp;
  assign bus.sym_last  = out_last;

endmodule

// File: doc/huffman_symbol_sequencer.md
# huffman_symbol_sequencer

Run-length sequencer ahead of the Huffman code stage. Accepts one 8×8 block of zigzag-ordered quantized coefficients, computes the DC difference against a running predictor, and walks AC coefficients 1..63. It emits a stream of JPEG (run, size, amplitude) symbols, including ZRL and EOB, over a valid/ready handshake. The Huffman table lookup and bit packer downstream consume this stream one symbol per handshake.

## Interface
- No parameters. Coefficient width is 8-bit signed; block size is 64.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- zigzag_pix_in  in  512  64 signed 8-bit coefficients; coefficient k at [8k+7:8k]; k=0 is DC.
- blk_valid  in  1  block present on zigzag_pix_in.
- blk_ready  out  1  sequencer can accept a block.
- dc_pred_clr  in  1  clear DC predictor to 0 (frame/scan start).
- sym_valid  out  1  symbol registers valid.
- sym_ready  in  1  downstream accepts symbol.
- sym_is_dc  out  1  symbol is the DC difference.
- sym_run  out  4  zero run preceding the coefficient; 15 for ZRL; 0 for DC/EOB.
- sym_size  out  4  magnitude category 0..8.
- sym_amp  out  8  amplitude bits, low sym_size bits significant, upper bits 0.
- sym_last  out  1  final symbol of the block.
- busy  out  1  block in progress (state ≠ IDLE).

## Operation
- States are IDLE, DC, SCAN, DONE.
- IDLE: blk_ready=1. On blk_valid&&blk_ready, latch all 512 bits and compute diff = coef0 − pred as a 9-bit signed value. Then set pred ← coef0, load the DC symbol into the output registers, and go to DC.
- DC: hold the DC symbol (is_dc=1, run=0) until the handshake. Then set k←1, run←0, and go to SCAN.
- SCAN evaluates coefficient k only in a cycle where the output register is free (!sym_valid, or sym_valid&&sym_ready).
  - coef[k]==0: run++, k++, no emission.
  - coef[k]≠0 and run≥16: emit ZRL (run=15, size=0, amp=0). Then run−=16 and k is unchanged.
  - coef[k]≠0 and run<16: emit (run, size, amp). Then run←0 and k++.
- End of scan, after k=63 is processed:
  - coef[63]≠0: the symbol for k=63 carries sym_last=1. No EOB is emitted.
  - otherwise: emit EOB (run=0, size=0, amp=0, last=1).
  - Either way, go to DONE.
- Trailing zeros never produce ZRL; ZRL is only issued when a nonzero coefficient follows.
- DONE: wait for the last symbol's handshake, then go to IDLE.
- Size/amp rule, applied to the DC diff and to AC values:
  - size = bit length of |v|; size=0 for v=0.
  - amp = v for v>0.
  - amp = v + 2^size − 1 for v<0, i.e. the low size bits of v−1.
  - Examples: 5→(3, 101); −3→(2, 00); −128→(8, 0111_1111); DC diff −255→(8, 0000_0000).
- Predictor:
  - pred resets to 0.
  - dc_pred_clr in any non-accept cycle sets pred←0.
  - dc_pred_clr in the accept cycle: the diff uses pred=0, and pred still loads coef0.

## Timing
- Reset values:
  - sym_valid, sym_is_dc, sym_run, sym_size, sym_amp, sym_last, busy = 0.
  - blk_ready=1; state=IDLE; pred=0; k=0; run=0.
- blk_ready is decoded combinationally from state==IDLE. A new block is accepted no earlier than the cycle after the last symbol handshake.
- All sym_* outputs are registered. The DC symbol is valid the cycle after accept.
- While sym_valid && !sym_ready, all sym_* outputs hold stable and SCAN stalls (k and run frozen).
- Zero coefficients cost one cycle each with no output. With sym_ready held high, each emitted symbol costs one cycle.
- Worst case, all AC nonzero: 64 symbols in 64 consecutive cycles after accept.
- zigzag_pix_in is sampled only at accept; later changes are ignored.
- Asserting reset_n low mid-block:
  - outputs and state return immediately to their reset values;
  - the partial block is discarded and pred returns to 0.

## Test plan
- After reset, block with coef0=10 and all AC 0 → DC (is_dc=1, size=4, amp=1010); then EOB (run=0, size=0, last=1); then blk_ready=1.
- Next block coef0=7 → DC diff −3 (size=2, amp=00). Repeat with dc_pred_clr=1 in the accept cycle → diff 7 (size=3, amp=111).
- coef1=−1, coef20=5, others 0 → DC; (0, 1, 0); ZRL (15, 0, 0); (2, 3, 101); EOB last.
- All AC=1, sym_ready=1 → 64 symbols on consecutive cycles; the k=63 symbol is (0, 1, 1) with last=1; no EOB.
- Same stimulus with sym_ready toggling pseudo-randomly → identical symbol sequence; outputs stable during every stall cycle.
- Pull reset_n low during SCAN → all outputs 0 and blk_ready=1 immediately. The next block with coef0=4 gives diff 4 (predictor cleared).
